axi2native: RTL and testbench
=============================

// Module: axi2native
// PURPOSE
// AXI4-Lite slave (responder) that converts AXI-Lite transactions into the native valid/ready
// register-access interface used across the design. It is the inverse of the native-to-AXI
// bridge: it lets native-interface peripherals sit behind an AXI-Lite master.
// Write and read paths are independent; one outstanding transaction per path.
// PARAMETERS
// ADDR_W  4   address width, both AXI and native sides
// DATA_W  32  data width; STRB_W = DATA_W/8
// PORTS
// clk_i          in   1        clock
// rst_n_i        in   1        reset, asynchronous, active-low
// s_axi_awaddr   in   ADDR_W   write address
// s_axi_awvalid  in   1        | s_axi_awready out 1
// s_axi_wdata    in   DATA_W   write data
// s_axi_wstrb    in   STRB_W   byte strobes
// s_axi_wvalid   in   1        | s_axi_wready  out 1
// s_axi_bresp    out  2        write response
// s_axi_bvalid   out  1        | s_axi_bready  in  1
// s_axi_araddr   in   ADDR_W   read address
// s_axi_arvalid  in   1        | s_axi_arready out 1
// s_axi_rdata    out  DATA_W   read data
// s_axi_rresp    out  2        read response
// s_axi_rvalid   out  1        | s_axi_rready  in  1
// wr_valid_o     out  1        native write request; wr_addr_o ADDR_W, wr_data_o DATA_W, wr_strb_o STRB_W
// wr_ready_i     in   1        write accepted; wr_err_i (1) is sampled in the same cycle
// rd_valid_o     out  1        native read request; rd_addr_o ADDR_W
// rd_ready_i     in   1        read done; rd_data_i (DATA_W) and rd_err_i (1) are sampled in the same cycle
// BEHAVIOUR
// - All outputs are registered. Reset values: every ready and valid = 0, bresp/rresp = 0, data/addr/strb = 0.
//   awready, wready and arready rise in the first cycle after reset deassertion.
// - Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
//   - W_IDLE: AW and W are captured independently, in either order and any cycle skew.
//     awready drops after the AW capture; wready drops after the W capture.
//     Go to W_REQ once both are held.
//   - W_REQ: wr_valid_o = 1 with address/data/strobes stable until wr_ready_i.
//     At handshake: bresp = wr_err_i ? 2'b10 (SLVERR) : 2'b00 (OKAY).
//   - W_RESP: bvalid = 1 until bready, then re-arm awready/wready.
// - Read FSM: R_IDLE (arready = 1) -> R_REQ -> R_RESP -> R_IDLE.
//   - R_REQ: rd_valid_o = 1 until rd_ready_i. At handshake: rdata = rd_data_i, rresp = SLVERR/OKAY from rd_err_i.
//   - R_RESP: rvalid = 1 with rdata/rresp stable until rready.
// - Latency, best case (AW+W in cycle 0, ready_i immediate): wr_valid_o in cycle 1, bvalid in cycle 2.
//   Read is the same: AR in cycle 0, rd_valid_o in cycle 1, rvalid in cycle 2. Throughput is one transaction per 3 cycles.
// - Back-pressure: bready/rready low holds bvalid/rvalid and their payload. No new AW/W/AR is accepted meanwhile.
// - Concurrency: a read and a write may be in flight together; the native wr and rd ports are driven simultaneously.
// - Address and strobes pass through unmodified; no alignment check and no decode error.
// - Reset mid-transaction: asynchronous abort to idle. No pending B/R or native request is emitted afterwards.
// STRUCTURE
// - Shared package axil_pkg:
//   - typedef axil_resp_t (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11)
//   - wr_state_t {W_IDLE, W_REQ, W_RESP}
//   - rd_state_t {R_IDLE, R_REQ, R_RESP}
// - No sub-module: the write and read FSMs are two always_ff blocks in this file.
// TESTING
// 1) AW+W in the same cycle, addr 4'h4, data 32'hDEADBEEF, strb 4'hF, wr_ready_i=1 immediately
//    -> wr_valid_o in cycle 1 with those values, bvalid in cycle 2, bresp=2'b00.
// 2) W (data 32'h12345678) leads AW (addr 4'hC) by 5 cycles
//    -> wready low after W; wr_valid_o only after AW, carrying addr 4'hC and data 32'h12345678.
// 3) Read addr 4'h8, rd_ready_i delayed 4 cycles with rd_data_i=32'hA5A5A5A5, rd_err_i=1
//    -> rd_valid_o held 4 cycles, then rvalid with rdata=32'hA5A5A5A5, rresp=2'b10.
// 4) bready held low 10 cycles after a write
//    -> bvalid/bresp stable; awready=wready=0 throughout; a second AW is accepted only after B completes.
// 5) Concurrent write to 4'h4 and read of 4'h0 issued in the same cycle
//    -> wr_valid_o and rd_valid_o both assert in cycle 1; B and R complete independently.
// 6) rst_n_i pulsed low while in W_REQ
//    -> wr_valid_o=0 immediately; no bvalid afterwards; awready=1 in the first cycle after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes and the write/read FSM state encodings
// used by the AXI-Lite to native register-access bridge.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_t;

  function automatic axil_resp_t err_to_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi2native.sv
// AXI4-Lite responder that turns AXI-Lite writes/reads into native valid/ready
// register requests. Independent write and read paths, one outstanding each.
module axi2native
  import axil_pkg::*;
#(
  parameter  int ADDR_W = 4,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [STRB_W-1:0] wr_strb_o,
  input  logic              wr_ready_i,
  input  logic              wr_err_i,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_ready_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_err_i
);

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;
  logic      aw_held, w_held;
  logic      aw_fire, w_fire, ar_fire;
  logic      aw_have, w_have;

  // The ready flags are only ever high in the idle states, so a fire implies idle.
  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid  & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;
  assign aw_have = aw_held | aw_fire;
  assign w_have  = w_held  | w_fire;

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_state_n = wr_state;
    unique case (wr_state)
      W_IDLE:  if (aw_have && w_have) wr_state_n = W_REQ;
      W_REQ:   if (wr_ready_i)        wr_state_n = W_RESP;
      W_RESP:  if (s_axi_bready)      wr_state_n = W_IDLE;
      default:                        wr_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_fire)      rd_state_n = R_REQ;
      R_REQ:   if (rd_ready_i)   rd_state_n = R_RESP;
      R_RESP:  if (s_axi_rready) rd_state_n = R_IDLE;
      default:                   rd_state_n = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_state      <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      wr_valid_o    <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      wr_strb_o     <= '0;
    end else begin
      wr_state <= wr_state_n;
      unique case (wr_state)
        W_IDLE: begin
          // AW and W are captured independently; each ready drops once its beat is held.
          if (aw_fire) begin
            wr_addr_o <= s_axi_awaddr;
            aw_held   <= 1'b1;
          end
          if (w_fire) begin
            wr_data_o <= s_axi_wdata;
            wr_strb_o <= s_axi_wstrb;
            w_held    <= 1'b1;
          end
          s_axi_awready <= !aw_have;
          s_axi_wready  <= !w_have;
          wr_valid_o    <= aw_have && w_have;
        end
        W_REQ: if (wr_ready_i) begin
          wr_valid_o   <= 1'b0;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= err_to_resp(wr_err_i);
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          aw_held       <= 1'b0;
          w_held        <= 1'b0;
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
      rd_valid_o    <= 1'b0;
      rd_addr_o     <= '0;
    end else begin
      rd_state <= rd_state_n;
      unique case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rd_addr_o  <= s_axi_araddr;
            rd_valid_o <= 1'b1;
          end
          s_axi_arready <= !ar_fire;
        end
        R_REQ: if (rd_ready_i) begin
          rd_valid_o   <= 1'b0;
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= rd_data_i;
          s_axi_rresp  <= err_to_resp(rd_err_i);
        end
        R_RESP: if (s_axi_rready) begin
          s_axi_rvalid  <= 1'b0;
          s_axi_arready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2native.sv
// Bench for axi2native: directed scenarios for latency, skew, back-pressure and reset,
// then randomized traffic checked against a queue-based transaction model.
module tb_axi2native;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int RND_CYCLES = 1500;
  localparam int DRAIN      = 200;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid, s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wvalid, s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid, s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid, s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid, s_axi_rready;
  logic              wr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [STRB_W-1:0] wr_strb_o;
  logic              wr_ready_i, wr_err_i;
  logic              rd_valid_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_ready_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_err_i;

  axi2native #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .wr_ready_i(wr_ready_i), .wr_err_i(wr_err_i),
    .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o), .rd_ready_i(rd_ready_i),
    .rd_data_i(rd_data_i), .rd_err_i(rd_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata  = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    wr_ready_i = 1'b0; wr_err_i = 1'b0;
    rd_ready_i = 1'b0; rd_data_i = '0; rd_err_i = 1'b0;
  endtask

  // Transaction model: accepted AXI beats queue up in order; each native request must
  // match the oldest AW/W pair (or AR), and each response must follow the error rule.
  logic [ADDR_W-1:0]        aw_q[$];
  logic [ADDR_W-1:0]        ar_q[$];
  logic [STRB_W+DATA_W-1:0] w_q[$];
  logic [1:0]               b_q[$];
  logic [DATA_W+1:0]        r_q[$];

  initial begin
    int  aw_sent, w_sent, ar_sent, wr_done, rd_done;
    bit  issue, drain, hs_aw, hs_w, hs_ar;
    logic [DATA_W-1:0] rdat;

    idle_inputs();

    // Reset state
    tick(); tick();
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready",  s_axi_wready,  0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_valids",  {s_axi_bvalid, s_axi_rvalid, wr_valid_o, rd_valid_o}, 0);
    check("rst_resps",   {s_axi_bresp, s_axi_rresp}, 0);
    check("rst_payload", {s_axi_rdata, wr_addr_o, rd_addr_o, wr_strb_o}, 0);
    check("rst_wr_data", wr_data_o, 0);
    rst_n_i = 1'b1;
    tick();
    check("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // 1) AW+W same cycle, immediate native ready
    s_axi_awvalid = 1; s_axi_awaddr = 4'h4;
    s_axi_wvalid = 1; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
    wr_ready_i = 1; wr_err_i = 0;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("t1_wr_valid_c1", wr_valid_o, 1);
    check("t1_wr_addr", wr_addr_o, 4'h4);
    check("t1_wr_data", wr_data_o, 32'hDEADBEEF);
    check("t1_wr_strb", wr_strb_o, 4'hF);
    check("t1_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
    tick();
    wr_ready_i = 0;
    check("t1_bvalid_c2", s_axi_bvalid, 1);
    check("t1_bresp", s_axi_bresp, 2'b00);
    check("t1_wr_valid_dropped", wr_valid_o, 0);
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;
    check("t1_b_done", s_axi_bvalid, 0);
    check("t1_rearm", {s_axi_awready, s_axi_wready}, 2'b11);

    // 2) W leads AW by 5 cycles
    s_axi_wvalid = 1; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'h3;
    tick();
    s_axi_wvalid = 0;
    check("t2_wready_low", s_axi_wready, 0);
    check("t2_awready_high", s_axi_awready, 1);
    for (int i = 0; i < 4; i++) begin
      check("t2_no_wr_valid", wr_valid_o, 0);
      tick();
    end
    check("t2_wready_still_low", s_axi_wready, 0);
    s_axi_awvalid = 1; s_axi_awaddr = 4'hC;
    tick();
    s_axi_awvalid = 0;
    check("t2_wr_valid", wr_valid_o, 1);
    check("t2_wr_addr", wr_addr_o, 4'hC);
    check("t2_wr_data", wr_data_o, 32'h12345678);
    check("t2_wr_strb", wr_strb_o, 4'h3);
    wr_ready_i = 1;
    tick();
    wr_ready_i = 0;
    check("t2_bvalid", s_axi_bvalid, 1);
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;

    // 3) Read with native ready delayed 4 cycles and an error
    s_axi_arvalid = 1; s_axi_araddr = 4'h8;
    tick();
    s_axi_arvalid = 0;
    check("t3_arready_low", s_axi_arready, 0);
    check("t3_rd_addr", rd_addr_o, 4'h8);
    for (int i = 0; i < 4; i++) begin
      check("t3_rd_valid_held", rd_valid_o, 1);
      tick();
    end
    rd_ready_i = 1; rd_data_i = 32'hA5A5A5A5; rd_err_i = 1;
    check("t3_rd_valid_at_hs", rd_valid_o, 1);
    tick();
    rd_ready_i = 0; rd_data_i = '0; rd_err_i = 0;
    check("t3_rvalid", s_axi_rvalid, 1);
    check("t3_rdata", s_axi_rdata, 32'hA5A5A5A5);
    check("t3_rresp", s_axi_rresp, 2'b10);
    check("t3_rd_valid_dropped", rd_valid_o, 0);
    s_axi_rready = 1;
    tick();
    s_axi_rready = 0;
    check("t3_r_done", s_axi_rvalid, 0);
    check("t3_arready_rearm", s_axi_arready, 1);

    // 4) B back-pressure for 10 cycles with a second write waiting
    s_axi_awvalid = 1; s_axi_awaddr = 4'h2;
    s_axi_wvalid = 1; s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'h5;
    wr_ready_i = 1; wr_err_i = 1;
    tick();
    s_axi_awaddr = 4'h6; s_axi_wdata = 32'hCAFE0001; s_axi_wstrb = 4'hA;
    tick();
    wr_ready_i = 0; wr_err_i = 0;
    for (int i = 0; i < 10; i++) begin
      check("t4_bvalid_held", s_axi_bvalid, 1);
      check("t4_bresp_held", s_axi_bresp, 2'b10);
      check("t4_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
      tick();
    end
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;
    check("t4_b_done", s_axi_bvalid, 0);
    check("t4_second_not_yet", wr_valid_o, 0);
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("t4_second_wr_valid", wr_valid_o, 1);
    check("t4_second_addr", wr_addr_o, 4'h6);
    check("t4_second_data", wr_data_o, 32'hCAFE0001);
    wr_ready_i = 1;
    tick();
    wr_ready_i = 0;
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;

    // 5) Concurrent write and read
    rdat = $urandom;
    s_axi_awvalid = 1; s_axi_awaddr = 4'h4;
    s_axi_wvalid = 1; s_axi_wdata = 32'h55AA55AA; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1; s_axi_araddr = 4'h0;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    check("t5_both_valid", {wr_valid_o, rd_valid_o}, 2'b11);
    check("t5_rd_addr", rd_addr_o, 4'h0);
    wr_ready_i = 1; rd_ready_i = 1; rd_data_i = rdat;
    tick();
    wr_ready_i = 0; rd_ready_i = 0;
    check("t5_both_resp", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    check("t5_rdata", s_axi_rdata, rdat);
    s_axi_rready = 1;
    tick();
    s_axi_rready = 0;
    check("t5_r_only_done", {s_axi_bvalid, s_axi_rvalid}, 2'b10);
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;
    check("t5_b_done", s_axi_bvalid, 0);

    // 6) Asynchronous reset while in W_REQ
    s_axi_awvalid = 1; s_axi_awaddr = 4'h9;
    s_axi_wvalid = 1; s_axi_wdata = 32'h0000FFFF;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("t6_in_req", wr_valid_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_wr_valid_async", wr_valid_o, 0);
    check("t6_awready_in_rst", s_axi_awready, 0);
    tick();
    rst_n_i = 1'b1;
    wr_ready_i = 1;
    tick();
    check("t6_awready_after", s_axi_awready, 1);
    check("t6_no_b_no_req", {s_axi_bvalid, wr_valid_o}, 2'b00);
    tick();
    check("t6_still_quiet", {s_axi_bvalid, wr_valid_o}, 2'b00);
    idle_inputs();
    tick();

    // Randomized traffic against the transaction model
    aw_sent = 0; w_sent = 0; ar_sent = 0; wr_done = 0; rd_done = 0;
    for (int cyc = 0; cyc < RND_CYCLES + DRAIN; cyc++) begin
      issue = (cyc < RND_CYCLES);
      drain = !issue;
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      hs_ar = s_axi_arvalid && s_axi_arready;
      if (hs_aw) begin aw_q.push_back(s_axi_awaddr); aw_sent++; end
      if (hs_w)  begin w_q.push_back({s_axi_wstrb, s_axi_wdata}); w_sent++; end
      if (hs_ar) begin ar_q.push_back(s_axi_araddr); ar_sent++; end
      if (wr_valid_o && wr_ready_i) begin
        if (aw_q.size() == 0 || w_q.size() == 0) check("rnd_wr_unexpected", 1, 0);
        else begin
          check("rnd_wr_addr", wr_addr_o, aw_q.pop_front());
          check("rnd_wr_strb_data", {wr_strb_o, wr_data_o}, w_q.pop_front());
        end
        b_q.push_back(wr_err_i ? 2'b10 : 2'b00);
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) check("rnd_b_unexpected", 1, 0);
        else check("rnd_bresp", s_axi_bresp, b_q.pop_front());
        wr_done++;
      end
      if (rd_valid_o && rd_ready_i) begin
        if (ar_q.size() == 0) check("rnd_rd_unexpected", 1, 0);
        else check("rnd_rd_addr", rd_addr_o, ar_q.pop_front());
        r_q.push_back({rd_err_i ? 2'b10 : 2'b00, rd_data_i});
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) check("rnd_r_unexpected", 1, 0);
        else check("rnd_rresp_rdata", {s_axi_rresp, s_axi_rdata}, r_q.pop_front());
        rd_done++;
      end
      tick();
      if (hs_aw) s_axi_awvalid = 0;
      if (hs_w)  s_axi_wvalid  = 0;
      if (hs_ar) s_axi_arvalid = 0;
      if (!s_axi_awvalid && aw_sent <= w_sent && (issue || aw_sent < w_sent)
          && $urandom_range(0, 2) == 0) begin
        s_axi_awvalid = 1; s_axi_awaddr = ADDR_W'($urandom);
      end
      if (!s_axi_wvalid && w_sent <= aw_sent && (issue || w_sent < aw_sent)
          && $urandom_range(0, 2) == 0) begin
        s_axi_wvalid = 1; s_axi_wdata = $urandom; s_axi_wstrb = STRB_W'($urandom);
      end
      if (!s_axi_arvalid && issue && $urandom_range(0, 2) == 0) begin
        s_axi_arvalid = 1; s_axi_araddr = ADDR_W'($urandom);
      end
      wr_ready_i   = drain | 1'($urandom_range(0, 1));
      wr_err_i     = 1'($urandom_range(0, 1));
      rd_ready_i   = drain | 1'($urandom_range(0, 1));
      rd_data_i    = $urandom;
      rd_err_i     = 1'($urandom_range(0, 1));
      s_axi_bready = drain | 1'($urandom_range(0, 1));
      s_axi_rready = drain | 1'($urandom_range(0, 1));
    end
    check("rnd_wr_activity", wr_done > 10, 1);
    check("rnd_rd_activity", rd_done > 10, 1);
    check("rnd_wr_all_done", wr_done, aw_sent);
    check("rnd_rd_all_done", rd_done, ar_sent);
    check("rnd_queues_empty", aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size(), 0);
    check("rnd_quiet_end", {s_axi_bvalid, s_axi_rvalid, wr_valid_o, rd_valid_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
